// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply / divide for the execute stage.
//
// Services R-type ALU op 6 (mult) and op 7 (div) held in the D/X register.
// A multi-cycle operation runs one shift-add (mult) or restoring-subtract
// (div) step per cycle on operand magnitudes and applies the sign at the end.
// The pipeline is stalled while the unit is busy.
//
// Ports:
//   clock           pipeline clock, rising edge
//   resetn          asynchronous active-low reset
//   dx_valid        DXIR holds a live instruction
//   DXIR            D/X instruction (opcode [31:27], ALU op [6:2])
//   data_operandA   rs: multiplicand / dividend
//   data_operandB   rt: multiplier / divisor
//   md_stall        freeze front of pipeline, bubble into X/M (combinational)
//   data_result     product low word or quotient (registered)
//   data_exception  overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY  one-cycle pulse, result valid
//   data_remainder  signed remainder (only with MULTDIV_REMAINDER_EN)
//
// Optional build macro: MULTDIV_REMAINDER_EN adds the data_remainder output.
//
// state | meaning
// IDLE  | waiting for a mult/div issue; operands latched on issue
// BUSY  | one iteration per cycle, WIDTH iterations total
// DONE  | result registered, data_resultRDY high for this cycle

module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             dx_valid,
    input  logic [31:0]      DXIR,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             md_stall,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef MULTDIV_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_is_div;
    logic             r_neg;      // sign of product / quotient
    logic             r_ovf;      // MIN_INT / -1 seen at issue
    logic [WIDTH-1:0] r_hi;       // upper product half / partial remainder
    logic [WIDTH-1:0] r_lo;       // multiplier bits / dividend-quotient bits
    logic [WIDTH-1:0] r_opnd;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;
`ifdef MULTDIV_REMAINDER_EN
    logic             r_sign_a;
    logic [WIDTH-1:0] r_rem;
`endif

    // Issue decode
    logic             w_issue;
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_zero;
    logic             w_div_ovf;
    logic             w_unused_dxir;

    assign w_is_div   = (DXIR[6:2] == 5'd7);
    assign w_issue    = dx_valid && (DXIR[31:27] == 5'd0) &&
                        ((DXIR[6:2] == 5'd6) || w_is_div);
    assign w_a_neg    = data_operandA[WIDTH-1];
    assign w_b_neg    = data_operandB[WIDTH-1];
    // MIN_INT negates to itself, which read unsigned is exactly its magnitude.
    assign w_a_mag    = w_a_neg ? -data_operandA : data_operandA;
    assign w_b_mag    = w_b_neg ? -data_operandB : data_operandB;
    assign w_div_zero = w_is_div && (data_operandB == '0);
    assign w_div_ovf  = w_is_div && (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (data_operandB == {WIDTH{1'b1}});
    assign w_unused_dxir = ^{DXIR[26:7], DXIR[1:0]};

    assign md_stall = resetn && (((r_state == S_IDLE) && w_issue) || (r_state == S_BUSY));

    // One iteration step, shared datapath registers for both operations
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_trial;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_opnd};

    always_comb begin
        w_hi_nxt = w_mul_sum[WIDTH:1];
        w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            // Partial remainder stays below the divisor, so WIDTH bits suffice.
            w_hi_nxt = w_div_trial[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], ~w_div_trial[WIDTH]};
        end
    end

    // Sign fixup on the final step's values
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_quot;

    assign w_prod_mag = {w_hi_nxt, w_lo_nxt};
    assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
    assign w_mul_exc  = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
    assign w_quot     = r_neg ? -w_lo_nxt : w_lo_nxt;

`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] w_rem;
    assign w_rem = r_sign_a ? -w_hi_nxt : w_hi_nxt;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            r_sign_a <= 1'b0;
            r_rem    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_count  <= '0;
                        r_is_div <= w_is_div;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_ovf    <= w_div_ovf;
                        r_hi     <= '0;
                        r_lo     <= w_is_div ? w_a_mag : w_b_mag;
                        r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
`ifdef MULTDIV_REMAINDER_EN
                        r_sign_a <= w_a_neg;
`endif
                        if (w_div_zero) begin
                            r_state  <= S_DONE;
                            r_result <= '0;
                            r_exc    <= 1'b1;
                            r_rdy    <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
                            r_rem    <= data_operandA;
`endif
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(WIDTH-1)) begin
                        r_state  <= S_DONE;
                        r_rdy    <= 1'b1;
                        r_result <= r_is_div ? w_quot : w_prod[WIDTH-1:0];
                        r_exc    <= r_is_div ? r_ovf : w_mul_exc;
`ifdef MULTDIV_REMAINDER_EN
                        r_rem    <= r_is_div ? w_rem : '0;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
`ifdef MULTDIV_REMAINDER_EN
    assign data_remainder = r_rem;
`endif

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: randomized and directed check of multdiv_unit against a
// 64-bit arithmetic reference model.

module tb_multdiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          dx_valid = 1'b0;
    logic [31:0]   DXIR = '0;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic          md_stall;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
`ifdef MULTDIV_REMAINDER_EN
    logic [W-1:0]  data_remainder;
`endif

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .dx_valid       (dx_valid),
        .DXIR           (DXIR),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .md_stall       (md_stall),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef MULTDIV_REMAINDER_EN
        ,
        .data_remainder (data_remainder)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_result = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit signed arithmetic
    task automatic ref_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [31:0] exc,
                          output logic [31:0] rem);
        longint la, lb, p, q, r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (!is_div) begin
            p   = la * lb;
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0]))) ? 1 : 0;
            rem = 0;
        end else if (b == 0) begin
            res = 0; exc = 1; rem = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000; exc = 1; rem = 0;
        end else begin
            q   = la / lb;
            r   = la % lb;
            res = q[31:0]; exc = 0; rem = r[31:0];
        end
    endtask

    function automatic logic [31:0] md_instr(input bit is_div);
        logic [19:0] mid;
        logic [1:0]  low;
        mid = 20'($urandom);
        low = 2'($urandom);
        return {5'd0, mid, (is_div ? 5'd7 : 5'd6), low};
    endfunction

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'($urandom_range(0, 50));
            1: v = -32'($urandom_range(1, 50));
            2: v = 32'h8000_0000;
            3: v = 32'hFFFF_FFFF;
            4: v = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 32'h0003_FFFF));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op, keep D/X held while stalled, scramble operands while busy,
    // then advance D/X after DONE.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] e_res, e_exc, e_rem;
        int exp_lat, k, stall_cnt;
        bit got;
        ref_op(is_div, a, b, e_res, e_exc, e_rem);
        exp_lat = (is_div && b == 0) ? 1 : W + 1;
        @(posedge clock); #1;
        dx_valid = 1'b1;
        DXIR = md_instr(is_div);
        data_operandA = a;
        data_operandB = b;
        k = 0; stall_cnt = 0; got = 0;
        while (!got && k <= 60) begin
            @(negedge clock);
            if (md_stall === 1'b1) stall_cnt++;
            if (data_resultRDY === 1'b1) got = 1;
            else begin
                @(posedge clock); #1;
                data_operandA = $urandom;
                data_operandB = $urandom;
                k++;
            end
        end
        check_val({tag, " ready"}, 32'(got), 32'd1);
        check_val({tag, " latency"}, k, exp_lat);
        check_val({tag, " stall_cycles"}, stall_cnt, exp_lat);
        check_val({tag, " result"}, data_result, e_res);
        check_val({tag, " exception"}, 32'(data_exception), e_exc);
`ifdef MULTDIV_REMAINDER_EN
        check_val({tag, " remainder"}, data_remainder, e_rem);
`endif
        @(posedge clock); #1;
        dx_valid = 1'b0;
        DXIR = $urandom;
        @(negedge clock);
        check_val({tag, " rdy_pulse_end"}, 32'(data_resultRDY), 32'd0);
        check_val({tag, " stall_after"}, 32'(md_stall), 32'd0);
        check_val({tag, " result_hold"}, data_result, e_res);
        last_result = e_res;
    endtask

    // Hold a non-md instruction for a while: nothing may happen
    task automatic idle_instr(input bit valid, input logic [31:0] instr, input string tag);
        int n_stall, n_rdy;
        n_stall = 0; n_rdy = 0;
        @(posedge clock); #1;
        dx_valid = valid;
        DXIR = instr;
        data_operandA = $urandom;
        data_operandB = 32'd3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (md_stall !== 1'b0) n_stall++;
            if (data_resultRDY !== 1'b0) n_rdy++;
        end
        check_val({tag, " stall_count"}, n_stall, 0);
        check_val({tag, " rdy_count"}, n_rdy, 0);
        check_val({tag, " result_kept"}, data_result, last_result);
        @(posedge clock); #1;
        dx_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #12;
        check_val("reset result", data_result, 32'd0);
        check_val("reset exception", 32'(data_exception), 32'd0);
        check_val("reset rdy", 32'(data_resultRDY), 32'd0);
        check_val("reset stall", 32'(md_stall), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;

        // Directed cases
        run_op(1'b0, 32'd7, -32'd3, "mult_7x-3");
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "mult_min_x-1");
        run_op(1'b1, -32'd7, 32'd2, "div_-7/2");
        run_op(1'b1, 32'd5, 32'd0, "div_by_zero");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
        run_op(1'b1, 32'd7, -32'd7, "div_7/-7");
        run_op(1'b1, 32'h8000_0000, 32'd1, "div_min/1");

        // Non-md instructions and bubbles
        idle_instr(1'b1, 32'h0000_0000, "add_op0");
        idle_instr(1'b1, {5'd1, 20'd0, 5'd6, 2'd0}, "nonR_op6");
        idle_instr(1'b0, {5'd0, 20'd0, 5'd7, 2'd0}, "bubble_div");

        // Asynchronous reset in the middle of a mult
        @(posedge clock); #1;
        dx_valid = 1'b1;
        DXIR = md_instr(1'b0);
        data_operandA = 32'd7;
        data_operandB = -32'd3;
        repeat (10) @(posedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check_val("midreset result", data_result, 32'd0);
        check_val("midreset exception", 32'(data_exception), 32'd0);
        check_val("midreset rdy", 32'(data_resultRDY), 32'd0);
        check_val("midreset stall", 32'(md_stall), 32'd0);
`ifdef MULTDIV_REMAINDER_EN
        check_val("midreset remainder", data_remainder, 32'd0);
`endif
        @(posedge clock); #1;
        dx_valid = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        last_result = 32'd0;
        run_op(1'b0, 32'd7, -32'd3, "mult_after_reset");

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            bit is_div;
            is_div = 1'($urandom);
            run_op(is_div, rnd_opnd(), rnd_opnd(), is_div ? "rand_div" : "rand_mult");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
